page_sequencer: RTL and testbench

Top-level display page controller for the entertainment system. It decides which page the VGA pixel mux shows: START (title plus "PRESS ANY KEY" prompt), PLAY (game field) or OVER (game-over screen). It latches key presses, changes pages only on frame boundaries to avoid tearing, and pulses a game reset on entry to PLAY. It also produces the blink enable for the prompt text drawn by the start and over page renderers.

---
 rtl/page_sequencer.sv | 141 ++++++++++++++
 tb/tb_page_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/page_sequencer.sv
// Display page controller: selects START/PLAY/OVER pages on frame boundaries,
// latches key presses, pulses game reset on PLAY entry and blinks the prompt.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PG_START | title page, prompt blinking, any key starts a game
// PG_PLAY  | game field shown, game logic running, keys ignored
// PG_OVER  | game-over page; hold phase ignores keys, ready phase blinks
// PG_BAD   | unreachable; next frame_start restores START reset values
module page_sequencer #(
   parameter int BLINK_FRAMES     = 30,
   parameter int OVER_HOLD_FRAMES = 120
) (
   input  logic       vga_clk,
   input  logic       sys_rst,
   input  logic       frame_start,
   input  logic       key_valid,
   input  logic       game_over,
   output logic [1:0] page_sel,
   output logic       prompt_en,
   output logic       game_rst,
   output logic       game_run
);

   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam int HW = $clog2(OVER_HOLD_FRAMES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(OVER_HOLD_FRAMES);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(OVER_HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      PG_START = 2'd0,
      PG_PLAY  = 2'd1,
      PG_OVER  = 2'd2,
      PG_BAD   = 2'd3
   } page_e;

   page_e         page_q, page_d;
   logic          prompt_q, prompt_d;
   logic          game_rst_q, game_rst_d;
   logic          game_run_q, game_run_d;
   logic          key_pending_q, key_pending_d;
   logic [BW-1:0] blink_q, blink_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          key_eff;
   logic          do_blink;

   always_comb begin
      page_d     = page_q;
      prompt_d   = prompt_q;
      game_rst_d = 1'b0;
      game_run_d = game_run_q;
      blink_d    = blink_q;
      hold_d     = hold_q;
      do_blink   = 1'b0;
      key_eff    = key_pending_q | key_valid;
      // A same-cycle key is consumed by frame_start; otherwise it waits.
      key_pending_d = key_eff & ~frame_start;

      if (frame_start) begin
         case (page_q)
            PG_START: begin
               if (key_eff) begin
                  page_d     = PG_PLAY;
                  game_rst_d = 1'b1;
                  game_run_d = 1'b1;
                  prompt_d   = 1'b0;
                  blink_d    = '0;
               end else begin
                  do_blink = 1'b1;
               end
            end
            PG_PLAY: begin
               if (game_over) begin
                  page_d     = PG_OVER;
                  game_run_d = 1'b0;
                  prompt_d   = 1'b0;
                  hold_d     = '0;
               end
            end
            PG_OVER: begin
               if (hold_q != HOLD_MAX) begin
                  hold_d = hold_q + HW'(1);
                  if (hold_q == HOLD_LAST) begin
                     prompt_d = 1'b1;
                     blink_d  = '0;
                  end
               end else if (key_eff) begin
                  page_d   = PG_START;
                  prompt_d = 1'b1;
                  blink_d  = '0;
               end else begin
                  do_blink = 1'b1;
               end
            end
            default: begin
               page_d     = PG_START;
               prompt_d   = 1'b1;
               game_run_d = 1'b0;
               blink_d    = '0;
               hold_d     = '0;
            end
         endcase

         if (do_blink) begin
            if (blink_q == BLINK_LAST) begin
               blink_d  = '0;
               prompt_d = ~prompt_q;
            end else begin
               blink_d = blink_q + BW'(1);
            end
         end
      end
   end

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         page_q        <= PG_START;
         prompt_q      <= 1'b1;
         game_rst_q    <= 1'b0;
         game_run_q    <= 1'b0;
         key_pending_q <= 1'b0;
         blink_q       <= '0;
         hold_q        <= '0;
      end else begin
         page_q        <= page_d;
         prompt_q      <= prompt_d;
         game_rst_q    <= game_rst_d;
         game_run_q    <= game_run_d;
         key_pending_q <= key_pending_d;
         blink_q       <= blink_d;
         hold_q        <= hold_d;
      end
   end

   assign page_sel  = page_q;
   assign prompt_en = prompt_q;
   assign game_rst  = game_rst_q;
   assign game_run  = game_run_q;

endmodule

// File: tb/tb_page_sequencer.sv
// Directed and randomized bench for page_sequencer with a per-cycle
// behavioural reference model of the page/prompt rules.
module tb_page_sequencer;

   localparam int BF = 2;
   localparam int HF = 4;

   logic       vga_clk = 1'b0;
   logic       sys_rst;
   logic       frame_start;
   logic       key_valid;
   logic       game_over;
   logic [1:0] page_sel;
   logic       prompt_en;
   logic       game_rst;
   logic       game_run;

   page_sequencer #(
      .BLINK_FRAMES     (BF),
      .OVER_HOLD_FRAMES (HF)
   ) dut (
      .vga_clk     (vga_clk),
      .sys_rst     (sys_rst),
      .frame_start (frame_start),
      .key_valid   (key_valid),
      .game_over   (game_over),
      .page_sel    (page_sel),
      .prompt_en   (prompt_en),
      .game_rst    (game_rst),
      .game_run    (game_run)
   );

   always #5 vga_clk = ~vga_clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: page 0=START 1=PLAY 2=OVER
   int m_page;
   bit m_prompt, m_rst, m_run, m_key;
   int m_blink, m_hold;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_page = 0; m_prompt = 1; m_rst = 0; m_run = 0;
      m_key = 0; m_blink = 0; m_hold = 0;
   endtask

   task automatic blink_step();
      if (m_blink == BF - 1) begin
         m_blink  = 0;
         m_prompt = !m_prompt;
      end else begin
         m_blink++;
      end
   endtask

   task automatic model_clock(input bit fs, input bit kv, input bit go);
      bit keff;
      m_rst = 0;
      if (!fs) begin
         if (kv) m_key = 1;
         return;
      end
      keff  = m_key | kv;
      m_key = 0;
      if (m_page == 0) begin
         if (keff) begin
            m_page = 1; m_rst = 1; m_run = 1; m_prompt = 0; m_blink = 0;
         end else begin
            blink_step();
         end
      end else if (m_page == 1) begin
         if (go) begin
            m_page = 2; m_run = 0; m_hold = 0;
         end
      end else begin
         if (m_hold < HF) begin
            m_hold++;
            if (m_hold == HF) begin
               m_prompt = 1; m_blink = 0;
            end
         end else if (keff) begin
            m_page = 0; m_prompt = 1; m_blink = 0;
         end else begin
            blink_step();
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_page"},   page_sel,  m_page);
      check({tag, "_prompt"}, prompt_en, m_prompt);
      check({tag, "_grst"},   game_rst,  m_rst);
      check({tag, "_grun"},   game_run,  m_run);
   endtask

   task automatic step(input bit fs, input bit kv, input bit go);
      frame_start = fs;
      key_valid   = kv;
      game_over   = go;
      @(posedge vga_clk);
      if (sys_rst) model_reset();
      else model_clock(fs, kv, go);
      #1;
      check_model("cyc");
   endtask

   task automatic idle(input int n, input bit go);
      repeat (n) step(1'b0, 1'b0, go);
   endtask

   task automatic frame(input bit kv, input bit go);
      idle(4, go);
      step(1'b1, kv, go);
   endtask

   int blink_exp[4] = '{1, 0, 0, 1};
   bit go_lvl;

   initial begin
      sys_rst = 1'b1; frame_start = 1'b0; key_valid = 1'b0; game_over = 1'b0;
      model_reset();
      #1;
      check("rst_page", page_sel, 0);
      check("rst_prompt", prompt_en, 1);
      check("rst_grst", game_rst, 0);
      check("rst_grun", game_run, 0);
      @(posedge vga_clk); #1;
      sys_rst = 1'b0;
      step(0, 0, 0);

      // blink cadence in START
      for (int i = 0; i < 4; i++) begin
         frame(0, 0);
         check("blink_prompt", prompt_en, blink_exp[i]);
         check("blink_page", page_sel, 0);
      end

      // key well before frame_start
      step(0, 1, 0);
      idle(99, 0);
      step(1, 0, 0);
      check("play_page", page_sel, 1);
      check("play_run", game_run, 1);
      check("play_grst", game_rst, 1);
      check("play_prompt", prompt_en, 0);
      step(0, 0, 0);
      check("play_grst_once", game_rst, 0);

      // game_over between frames takes effect at frame_start
      step(0, 0, 1);
      check("go_wait_page", page_sel, 1);
      idle(3, 1);
      step(1, 0, 1);
      check("over_page", page_sel, 2);
      check("over_run", game_run, 0);

      // hold phase ignores keys
      for (int i = 0; i < 3; i++) begin
         frame(1, 0);
         check("hold_page", page_sel, 2);
         check("hold_prompt", prompt_en, 0);
      end
      frame(1, 0);
      check("ready_prompt", prompt_en, 1);
      check("ready_page", page_sel, 2);
      frame(1, 0);
      check("over_to_start", page_sel, 0);
      check("over_to_start_prompt", prompt_en, 1);

      // key one cycle after frame_start waits a frame
      frame(0, 0);
      step(0, 1, 0);
      check("late_key_page", page_sel, 0);
      idle(3, 0);
      check("late_key_wait", page_sel, 0);
      step(1, 0, 0);
      check("late_key_play", page_sel, 1);

      // keys during PLAY are ignored
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0);
         frame(1, 0);
         check("play_keys_page", page_sel, 1);
         check("play_keys_grst", game_rst, 0);
      end

      // a late PLAY key must not survive into OVER
      idle(2, 1);
      step(0, 1, 1);
      step(1, 0, 1);
      check("leak_over", page_sel, 2);
      for (int i = 0; i < 4; i++) frame(0, 0);
      check("leak_ready", prompt_en, 1);
      frame(0, 0);
      check("leak_stay", page_sel, 2);
      frame(1, 0);
      check("back_start", page_sel, 0);

      // coincident key and frame_start
      frame(1, 0);
      check("coincident_play", page_sel, 1);
      check("coincident_grst", game_rst, 1);

      // async reset mid-OVER with hold at 2
      frame(0, 1);
      check("rst2_over", page_sel, 2);
      frame(0, 0);
      frame(0, 0);
      #2;
      sys_rst = 1'b1;
      #1;
      check("async_page", page_sel, 0);
      check("async_prompt", prompt_en, 1);
      check("async_run", game_run, 0);
      check("async_grst", game_rst, 0);
      model_reset();
      step(0, 0, 0);
      sys_rst = 1'b0;
      step(0, 0, 0);
      frame(1, 0);
      check("rst2_play", page_sel, 1);
      frame(0, 1);
      check("rst2_over_again", page_sel, 2);
      for (int i = 0; i < 3; i++) begin
         frame(0, 0);
         check("rst2_hold_prompt", prompt_en, 0);
      end
      frame(0, 0);
      check("rst2_ready_prompt", prompt_en, 1);

      // randomized traffic against the model
      go_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) go_lvl = !go_lvl;
         step($urandom_range(7) == 0, $urandom_range(9) == 0, go_lvl);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
